card_blit_ctrl: RTL and testbench

- Sequences one 512-entry x 3-bit card sprite memory (sync-read, 1-cycle latency) to copy a whole card into the 256x240 framebuffer at a requested (x,y).
- Sits between the game logic (start/position/card select) and the framebuffer write port, which is shared with other writers through fb_ready.
- Skips off-screen pixels and, optionally, transparent pixels.

---
 rtl/card_blit_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_card_blit_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_blit_ctrl.sv
// card_blit_ctrl: copies one 16x32 card sprite from a sync-read card memory
// into the 256x240 framebuffer at a requested top-left position.
// Pixels are visited row-major; off-screen pixels are skipped. Framebuffer
// writes use a request/accept handshake: fb_we is held with stable
// fb_addr/fb_data until a cycle where fb_ready is also high, which completes
// the write.
// Optional feature macro: CARD_BLIT_TRANSPARENT_EN -- when defined, pixels
// whose colour equals TRANSP are skipped like clipped pixels.
module card_blit_ctrl #(
   parameter int          CARD_W = 16,
   parameter int          CARD_H = 32,
   parameter int          FB_W   = 256,
   parameter int          FB_H   = 240,
   parameter logic [2:0]  TRANSP = 3'b000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [5:0]  card_id,
   input  logic [7:0]  pos_x,
   input  logic [7:0]  pos_y,
   output logic        busy,
   output logic        done,
   output logic [5:0]  card_sel,
   output logic [8:0]  rd_addr,
   input  logic [2:0]  card_data,
   output logic        fb_we,
   output logic [15:0] fb_addr,
   output logic [2:0]  fb_data,
   input  logic        fb_ready,
   output logic [2:0]  dbg_state
);

   localparam int COL_W = $clog2(CARD_W);
   localparam int ROW_W = $clog2(CARD_H);

`ifdef CARD_BLIT_TRANSPARENT_EN
   localparam bit TRANSP_EN = 1'b1;
`else
   localparam bit TRANSP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LATCH = 3'd2,
      S_WRITE = 3'd3,
      S_ADV   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fb_we_q, fb_we_d;
   logic [8:0]       rd_addr_q, rd_addr_d;
   logic [15:0]      fb_addr_q, fb_addr_d;
   logic [2:0]       fb_data_q, fb_data_d;
   logic [5:0]       card_sel_q, card_sel_d;
   logic [7:0]       pos_x_q, pos_x_d;
   logic [7:0]       pos_y_q, pos_y_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;

   // 9-bit destination so a card hanging off the right/bottom edge never wraps
   logic [8:0] dx, dy;
   logic       skip_pix;
   logic       last_pix;

   // Destination coordinate, clip/transparency decision and last-pixel detect
   always_comb begin
      dx       = 9'(pos_x_q) + 9'(col_q);
      dy       = 9'(pos_y_q) + 9'(row_q);
      skip_pix = (dx >= 9'(FB_W)) || (dy >= 9'(FB_H)) ||
                 (TRANSP_EN && (card_data == TRANSP));
      last_pix = (row_q == ROW_W'(CARD_H - 1)) && (col_q == COL_W'(CARD_W - 1));
   end

   // Next-state and registered-output logic; all outputs come straight from flops
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      fb_we_d    = fb_we_q;
      rd_addr_d  = rd_addr_q;
      fb_addr_d  = fb_addr_q;
      fb_data_d  = fb_data_q;
      card_sel_d = card_sel_q;
      pos_x_d    = pos_x_q;
      pos_y_d    = pos_y_q;
      col_d      = col_q;
      row_d      = row_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               card_sel_d = card_id;
               pos_x_d    = pos_x;
               pos_y_d    = pos_y;
               col_d      = '0;
               row_d      = '0;
               rd_addr_d  = '0;
               busy_d     = 1'b1;
               state_d    = S_FETCH;
            end
         end
         // rd_addr is already valid here; the memory returns data next cycle
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            if (skip_pix) begin
               state_d = S_ADV;
            end else begin
               fb_addr_d = {dy[7:0], dx[7:0]};
               fb_data_d = card_data;
               fb_we_d   = 1'b1;
               state_d   = S_WRITE;
            end
         end
         S_WRITE: begin
            if (fb_ready) begin
               fb_we_d = 1'b0;
               state_d = S_ADV;
            end
         end
         S_ADV: begin
            if (col_q == COL_W'(CARD_W - 1)) begin
               col_d = '0;
               row_d = row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
            if (last_pix) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               // CARD_W is a power of two, so row*CARD_W+col is a concatenation
               rd_addr_d = 9'({row_d, col_d});
               state_d   = S_FETCH;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset abandons any blit in progress
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         fb_we_q    <= 1'b0;
         rd_addr_q  <= '0;
         fb_addr_q  <= '0;
         fb_data_q  <= '0;
         card_sel_q <= '0;
         pos_x_q    <= '0;
         pos_y_q    <= '0;
         col_q      <= '0;
         row_q      <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         fb_we_q    <= fb_we_d;
         rd_addr_q  <= rd_addr_d;
         fb_addr_q  <= fb_addr_d;
         fb_data_q  <= fb_data_d;
         card_sel_q <= card_sel_d;
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         col_q      <= col_d;
         row_q      <= row_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign fb_we     = fb_we_q;
   assign rd_addr   = rd_addr_q;
   assign fb_addr   = fb_addr_q;
   assign fb_data   = fb_data_q;
   assign card_sel  = card_sel_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_card_blit_ctrl.sv
// Directed bench for card_blit_ctrl: full on-screen blit, clipped blit,
// back-pressured write, ignored mid-blit start, reset mid-write, and the
// transparent-pixel case when CARD_BLIT_TRANSPARENT_EN is defined.
module tb_card_blit_ctrl;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [5:0]  card_id;
   logic [7:0]  pos_x;
   logic [7:0]  pos_y;
   logic        busy;
   logic        done;
   logic [5:0]  card_sel;
   logic [8:0]  rd_addr;
   logic [2:0]  card_data;
   logic        fb_we;
   logic [15:0] fb_addr;
   logic [2:0]  fb_data;
   logic        fb_ready;
   logic [2:0]  dbg_state;

   card_blit_ctrl dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .card_id   (card_id),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .busy      (busy),
      .done      (done),
      .card_sel  (card_sel),
      .rd_addr   (rd_addr),
      .card_data (card_data),
      .fb_we     (fb_we),
      .fb_addr   (fb_addr),
      .fb_data   (fb_data),
      .fb_ready  (fb_ready),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // ---------------- card memory model (sync read, 1-cycle latency) ----------------
   logic [2:0] mem [512];
   initial card_data = 3'd0;
   always @(posedge clock) card_data <= mem[rd_addr];

   // ---------------- scoreboard ----------------
   logic [18:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- write monitor (samples mid-cycle) ----------------
   int          acc_cnt   = 0;
   int          done_cnt  = 0;
   int          excl_viol = 0;
   int          hold_viol = 0;
   int          offscr    = 0;
   int          stall_wr  = 0;
   int          stall_cyc = 0;
   int          run       = 0;
   logic        pend      = 1'b0;
   logic [15:0] prev_addr = '0;
   logic [2:0]  prev_data = '0;
   logic [18:0] last_wr   = '0;

   initial forever begin
      @(negedge clock);
      if (reset_n) begin
         if (done && fb_we) excl_viol++;
         if (done) done_cnt++;
         if (fb_we) begin
            if (pend && (fb_addr != prev_addr || fb_data != prev_data)) hold_viol++;
            run++;
            if (fb_ready) begin
               acc_cnt++;
               last_wr = {fb_addr, fb_data};
               if (fb_addr[15:8] >= 8'd240) offscr++;
               if (run > 1) begin
                  stall_wr++;
                  stall_cyc += run - 1;
               end
               run  = 0;
               pend = 1'b0;
               if (exp_q.size() == 0) check("sb_extra_write", 32'(exp_q.size()), 1);
               else check("sb_write", 32'({fb_addr, fb_data}), 32'(exp_q.pop_front()));
            end else begin
               pend      = 1'b1;
               prev_addr = fb_addr;
               prev_data = fb_data;
            end
         end else begin
            run  = 0;
            pend = 1'b0;
         end
      end else begin
         run  = 0;
         pend = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   int start_cyc = 0;

   task automatic fill_mem_pattern();
      for (int a = 0; a < 512; a++) mem[a] = 3'(a);
   endtask

   // Expected write list for an opaque card at (px,py), row-major
   task automatic push_blit(input int px, input int py);
      for (int r = 0; r < 32; r++) begin
         for (int c = 0; c < 16; c++) begin
            int dx = px + c;
            int dy = py + r;
            if (dx < 256 && dy < 240) exp_q.push_back({8'(dy), 8'(dx), mem[r*16 + c]});
         end
      end
   endtask

   task automatic start_blit(input string tag, input logic [5:0] id, input logic [7:0] x,
                             input logic [7:0] y);
      @(posedge clock); #1;
      start   = 1'b1;
      card_id = id;
      pos_x   = x;
      pos_y   = y;
      @(posedge clock); #1;
      start     = 1'b0;
      card_id   = ~id;
      pos_x     = ~x;
      pos_y     = ~y;
      start_cyc = cyc;
      check({tag, "_busy_set"}, 32'(busy), 1);
   endtask

   task automatic wait_done(input string tag, input int budget, output int cycles);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(posedge clock); #1;
         n++;
      end
      check({tag, "_done_seen"}, 32'(done), 1);
      cycles = cyc - start_cyc;
      @(posedge clock); #1;
      check({tag, "_busy_after"}, 32'(busy), 0);
      check({tag, "_done_once"}, 32'(done), 0);
      check({tag, "_idle_after"}, 32'(dbg_state), 0);
   endtask

   task automatic wait_we(input string tag, input int budget);
      int n = 0;
      while (fb_we !== 1'b1 && n < budget) begin
         @(posedge clock); #1;
         n++;
      end
      check({tag, "_we_seen"}, 32'(fb_we), 1);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int cycles;
      int a0, d0, s0, sc0, o0;
      reset_n  = 1'b0;
      start    = 1'b0;
      card_id  = '0;
      pos_x    = '0;
      pos_y    = '0;
      fb_ready = 1'b1;
      fill_mem_pattern();
      #12;
      check("rst_busy",     32'(busy),      0);
      check("rst_done",     32'(done),      0);
      check("rst_fb_we",    32'(fb_we),     0);
      check("rst_rd_addr",  32'(rd_addr),   0);
      check("rst_fb_addr",  32'(fb_addr),   0);
      check("rst_fb_data",  32'(fb_data),   0);
      check("rst_card_sel", 32'(card_sel),  0);
      check("rst_state",    32'(dbg_state), 0);
      @(posedge clock); #1;
      reset_n = 1'b1;

      // T1: full card at (0,0), no back-pressure: 512 writes of 4 cycles each
      a0 = acc_cnt; d0 = done_cnt; s0 = stall_wr;
      push_blit(0, 0);
      check("t1_exp_count", 32'(exp_q.size()), 512);
      check("t1_exp_row0_end", 32'(exp_q[15]), 32'({16'h000F, 3'd7}));
      start_blit("t1", 6'd5, 8'd0, 8'd0);
      check("t1_card_sel", 32'(card_sel), 5);
      wait_done("t1", 3000, cycles);
      check("t1_cycles",   32'(cycles), 2048);
      check("t1_writes",   32'(acc_cnt - a0), 512);
      check("t1_last",     32'(last_wr), 32'({16'h1F0F, 3'd7}));
      check("t1_done_cnt", 32'(done_cnt - d0), 1);
      check("t1_stalls",   32'(stall_wr - s0), 0);
      check("t1_sb_empty", 32'(exp_q.size()), 0);

      // T2: clipped at (250,230): cols 0..5, rows 0..9 survive
      a0 = acc_cnt; o0 = offscr;
      push_blit(250, 230);
      check("t2_exp_count", 32'(exp_q.size()), 60);
      check("t2_exp_first", 32'(exp_q[0]), 32'({16'hE6FA, 3'd0}));
      start_blit("t2", 6'd9, 8'd250, 8'd230);
      wait_done("t2", 3000, cycles);
      check("t2_cycles",   32'(cycles), 60*4 + 452*3);
      check("t2_writes",   32'(acc_cnt - a0), 60);
      check("t2_last",     32'(last_wr), 32'({16'hEFFF, 3'd5}));
      check("t2_offscr",   32'(offscr - o0), 0);
      check("t2_sb_empty", 32'(exp_q.size()), 0);

      // T3: fb_ready low for 5 cycles on the 3rd write
      a0 = acc_cnt; s0 = stall_wr; sc0 = stall_cyc;
      push_blit(0, 0);
      start_blit("t3", 6'd1, 8'd0, 8'd0);
      begin
         int n = 0;
         while (acc_cnt - a0 < 2 && n < 50) begin
            @(posedge clock); #1;
            n++;
         end
         check("t3_two_writes", 32'(acc_cnt - a0), 2);
      end
      fb_ready = 1'b0;
      wait_we("t3", 20);
      repeat (5) @(posedge clock);
      #1;
      check("t3_we_held", 32'(fb_we), 1);
      check("t3_no_accept", 32'(acc_cnt - a0), 2);
      fb_ready = 1'b1;
      wait_done("t3", 3000, cycles);
      check("t3_cycles",    32'(cycles), 2048 + 5);
      check("t3_writes",    32'(acc_cnt - a0), 512);
      check("t3_stall_wr",  32'(stall_wr - s0), 1);
      check("t3_stall_cyc", 32'(stall_cyc - sc0), 5);
      check("t3_hold",      32'(hold_viol), 0);
      check("t3_sb_empty",  32'(exp_q.size()), 0);

      // T4: start pulsed mid-blit is ignored
      a0 = acc_cnt;
      push_blit(100, 50);
      start_blit("t4", 6'd3, 8'd100, 8'd50);
      repeat (100) @(posedge clock);
      #1;
      start   = 1'b1;
      card_id = 6'd7;
      pos_x   = 8'd1;
      pos_y   = 8'd1;
      @(posedge clock); #1;
      start = 1'b0;
      check("t4_card_sel", 32'(card_sel), 3);
      check("t4_busy", 32'(busy), 1);
      wait_done("t4", 3000, cycles);
      check("t4_cycles",   32'(cycles), 2048);
      check("t4_writes",   32'(acc_cnt - a0), 512);
      check("t4_sb_empty", 32'(exp_q.size()), 0);

      // T5: reset during WRITE abandons the blit at once
      a0 = acc_cnt;
      start_blit("t5", 6'd2, 8'd0, 8'd0);
      wait_we("t5", 20);
      #1;
      reset_n = 1'b0;
      #1;
      check("t5_rst_we",   32'(fb_we), 0);
      check("t5_rst_busy", 32'(busy),  0);
      check("t5_rst_done", 32'(done),  0);
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      repeat (20) @(posedge clock);
      #1;
      check("t5_no_writes", 32'(acc_cnt - a0), 0);
      check("t5_idle", 32'(dbg_state), 0);
      push_blit(0, 0);
      start_blit("t5b", 6'd4, 8'd0, 8'd0);
      wait_done("t5b", 3000, cycles);
      check("t5b_cycles",   32'(cycles), 2048);
      check("t5b_writes",   32'(acc_cnt - a0), 512);
      check("t5b_sb_empty", 32'(exp_q.size()), 0);

`ifdef CARD_BLIT_TRANSPARENT_EN
      // T6: all-transparent card except one pixel at row 1, col 1
      a0 = acc_cnt;
      for (int a = 0; a < 512; a++) mem[a] = 3'b000;
      mem[17] = 3'b101;
      exp_q.push_back({16'h150B, 3'b101});
      start_blit("t6", 6'd6, 8'd10, 8'd20);
      wait_done("t6", 3000, cycles);
      check("t6_cycles",   32'(cycles), 4 + 511*3);
      check("t6_writes",   32'(acc_cnt - a0), 1);
      check("t6_sb_empty", 32'(exp_q.size()), 0);
      fill_mem_pattern();
`endif

      check("we_done_excl", 32'(excl_viol), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
